// File: rtl/button_panel_pkg.sv
// Shared definitions for the alarm-clock button front end and the display mux.
package button_panel_pkg;

    // Width of the mode code; the display mux select reuses it.
    localparam int MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        CLOCK  = 3'd0,
        SET_TH = 3'd1,
        SET_TM = 3'd2,
        SET_AH = 3'd3,
        SET_AM = 3'd4
    } mode_t;

endpackage

// File: rtl/btn_debounce.sv
// Synchronizes one raw push-button and accepts a new level only after it has
// held for DB_CYCLES consecutive cycles; emits a one-cycle strobe on the press.
module btn_debounce #(
    parameter int DB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable,
    output logic press
);

    localparam int CW = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync_a;
    logic          s;
    logic          stable_d;
    logic [CW-1:0] cnt;

    // Two-flop synchronizer for the asynchronous button input.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a <= 1'b0;
            s      <= 1'b0;
        end else begin
            sync_a <= raw;
            s      <= sync_a;
        end
    end

    // Count how long s has disagreed with stable; any bounce back restarts the window.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
        end else begin
            stable_d <= stable;
            if (s == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= s;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign press = stable & ~stable_d;

endmodule

// File: rtl/button_panel.sv
// User-input side of the alarm clock: debounces five buttons, steps the mode
// FSM and generates up/down step pulses with auto-repeat in the SET_* states.
//
// state  | meaning
// CLOCK  | normal time display, no adjustment
// SET_TH | adjust time hours (fast clock selected)
// SET_TM | adjust time minutes (fast clock selected)
// SET_AH | adjust alarm hours
// SET_AM | adjust alarm minutes
module button_panel
    import button_panel_pkg::*;
#(
    parameter int DB_CYCLES    = 500000,
    parameter int REPEAT_DELAY = 50000000,
    parameter int REPEAT_RATE  = 10000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_c,
    input  logic              btn_l,
    input  logic              btn_r,
    input  logic              btn_u,
    input  logic              btn_d,
    output logic [MODE_W-1:0] mode,
    output logic              adjust,
    output logic              enth,
    output logic              entm,
    output logic              enah,
    output logic              enam,
    output logic              up,
    output logic              down
);

    localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int HW       = $clog2(HOLD_MAX);
    localparam logic [HW-1:0] DELAY_LD = HW'(REPEAT_DELAY - 1);
    localparam logic [HW-1:0] RATE_LD  = HW'(REPEAT_RATE - 1);

    logic stable_c, stable_l, stable_r, stable_u, stable_d;
    logic press_c, press_l, press_r, press_u, press_d;
    logic [2:0] unused_stable;

    mode_t   state, state_next;
    logic    step_fwd, step_back;
    logic    in_set, mode_chg, both_held;
    logic    fire_u, fire_d;
    logic [HW-1:0] hold_u, hold_d;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_c (.clk(clk), .rst(rst), .raw(btn_c), .stable(stable_c), .press(press_c));
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_l (.clk(clk), .rst(rst), .raw(btn_l), .stable(stable_l), .press(press_l));
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_r (.clk(clk), .rst(rst), .raw(btn_r), .stable(stable_r), .press(press_r));
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_u (.clk(clk), .rst(rst), .raw(btn_u), .stable(stable_u), .press(press_u));
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_d (.clk(clk), .rst(rst), .raw(btn_d), .stable(stable_d), .press(press_d));

    // Only up/down need the held level; the navigation buttons act on press alone.
    assign unused_stable = {stable_c, stable_l, stable_r};

    // l and r pressed together cancel each other.
    assign step_fwd  = press_r & ~press_l;
    assign step_back = press_l & ~press_r;

    // Mode state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLOCK;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; c has priority over l/r, illegal codes fall back to CLOCK.
    always_comb begin
        state_next = state;
        case (state)
            CLOCK: begin
                if (press_c) state_next = SET_TH;
            end
            SET_TH: begin
                if (press_c)        state_next = CLOCK;
                else if (step_fwd)  state_next = SET_TM;
                else if (step_back) state_next = SET_AM;
            end
            SET_TM: begin
                if (press_c)        state_next = CLOCK;
                else if (step_fwd)  state_next = SET_AH;
                else if (step_back) state_next = SET_TH;
            end
            SET_AH: begin
                if (press_c)        state_next = CLOCK;
                else if (step_fwd)  state_next = SET_AM;
                else if (step_back) state_next = SET_TM;
            end
            SET_AM: begin
                if (press_c)        state_next = CLOCK;
                else if (step_fwd)  state_next = SET_TH;
                else if (step_back) state_next = SET_AH;
            end
            default: state_next = CLOCK;
        endcase
    end

    // Level outputs decoded straight from the registered state.
    always_comb begin
        mode   = state;
        adjust = (state == SET_TH) || (state == SET_TM);
        enth   = (state == SET_TH);
        entm   = (state == SET_TM);
        enah   = (state == SET_AH);
        enam   = (state == SET_AM);
    end

    assign in_set    = (state == SET_TH) || (state == SET_TM) || (state == SET_AH) || (state == SET_AM);
    assign mode_chg  = (state_next != state);
    assign both_held = stable_u & stable_d;

    // A step fires on the press strobe or when the held direction's counter expires.
    assign fire_u = in_set & ~both_held & (press_u | (stable_u & (hold_u == '0)));
    assign fire_d = in_set & ~both_held & (press_d | (stable_d & (hold_d == '0)));

    // Per-direction hold down-counters: full delay after a press, then the repeat rate.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_u <= '0;
            hold_d <= '0;
        end else begin
            if (!in_set || mode_chg || both_held || !stable_u || press_u) hold_u <= DELAY_LD;
            else if (hold_u == '0)                                          hold_u <= RATE_LD;
            else                                                            hold_u <= hold_u - 1'b1;

            if (!in_set || mode_chg || both_held || !stable_d || press_d) hold_d <= DELAY_LD;
            else if (hold_d == '0)                                          hold_d <= RATE_LD;
            else                                                            hold_d <= hold_d - 1'b1;
        end
    end

    // Registered step pulses so they line up with the state update.
    always_ff @(posedge clk) begin
        if (rst) begin
            up   <= 1'b0;
            down <= 1'b0;
        end else begin
            up   <= fire_u;
            down <= fire_d;
        end
    end

endmodule

// File: tb/tb_button_panel.sv
// Directed bench for button_panel with short debounce/repeat parameters.
module tb_button_panel;
    import button_panel_pkg::*;

    logic       clk;
    logic       rst;
    logic       btn_c, btn_l, btn_r, btn_u, btn_d;
    logic [2:0] mode;
    logic       adjust, enth, entm, enah, enam;
    logic       up, down;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int overlap  = 0;
    int up_log[$];
    int dn_log[$];
    int exp_up[$];

    typedef struct {
        logic [4:0] btn;   // {c,l,r,u,d}
        int         mode;
        logic [4:0] en;    // {adjust,enth,entm,enah,enam}
    } vec_t;

    vec_t vecs[17];

    button_panel #(
        .DB_CYCLES(4),
        .REPEAT_DELAY(20),
        .REPEAT_RATE(5)
    ) dut (
        .clk(clk), .rst(rst),
        .btn_c(btn_c), .btn_l(btn_l), .btn_r(btn_r), .btn_u(btn_u), .btn_d(btn_d),
        .mode(mode), .adjust(adjust),
        .enth(enth), .entm(entm), .enah(enah), .enam(enam),
        .up(up), .down(down)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (up)         up_log.push_back(cyc);
            if (down)       dn_log.push_back(cyc);
            if (up && down) overlap++;
        end
    endtask

    task automatic drive(input logic [4:0] b);
        {btn_c, btn_l, btn_r, btn_u, btn_d} = b;
    endtask

    function automatic int en_bits();
        return int'({adjust, enth, entm, enah, enam});
    endfunction

    task automatic press_btn(input logic [4:0] b);
        drive(b);
        tick(7);
        drive(5'b00000);
        tick(8);
    endtask

    initial begin
        int prev_mode;
        int prev_en;
        int t0;
        int n;

        vecs[0]  = '{btn: 5'b10000, mode: 1, en: 5'b11000};
        vecs[1]  = '{btn: 5'b00100, mode: 2, en: 5'b10100};
        vecs[2]  = '{btn: 5'b00100, mode: 3, en: 5'b00010};
        vecs[3]  = '{btn: 5'b00100, mode: 4, en: 5'b00001};
        vecs[4]  = '{btn: 5'b00100, mode: 1, en: 5'b11000};
        vecs[5]  = '{btn: 5'b01000, mode: 4, en: 5'b00001};
        vecs[6]  = '{btn: 5'b10000, mode: 0, en: 5'b00000};
        vecs[7]  = '{btn: 5'b01000, mode: 0, en: 5'b00000};
        vecs[8]  = '{btn: 5'b00100, mode: 0, en: 5'b00000};
        vecs[9]  = '{btn: 5'b10000, mode: 1, en: 5'b11000};
        vecs[10] = '{btn: 5'b01100, mode: 1, en: 5'b11000};
        vecs[11] = '{btn: 5'b10100, mode: 0, en: 5'b00000};
        vecs[12] = '{btn: 5'b11000, mode: 1, en: 5'b11000};
        vecs[13] = '{btn: 5'b01000, mode: 4, en: 5'b00001};
        vecs[14] = '{btn: 5'b01000, mode: 3, en: 5'b00010};
        vecs[15] = '{btn: 5'b01000, mode: 2, en: 5'b10100};
        vecs[16] = '{btn: 5'b01000, mode: 1, en: 5'b11000};

        rst = 1'b1;
        drive(5'b00000);
        tick(3);
        rst = 1'b0;
        chk("reset_mode", int'(mode), 0);
        chk("reset_en", en_bits(), 0);
        chk("reset_up", int'(up), 0);
        chk("reset_down", int'(down), 0);

        // Bouncing c: never holds long enough to be accepted.
        for (int i = 0; i < 10; i++) begin
            btn_c = ~btn_c;
            tick(3);
        end
        drive(5'b00000);
        tick(8);
        chk("bounce_mode", int'(mode), 0);
        chk("bounce_en", en_bits(), 0);

        // Table of navigation presses: unchanged at edge 6, updated at edge 7.
        up_log.delete();
        dn_log.delete();
        prev_mode = 0;
        prev_en   = 0;
        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].btn);
            tick(6);
            chk($sformatf("vec%0d_pre_mode", i), int'(mode), prev_mode);
            chk($sformatf("vec%0d_pre_en", i), en_bits(), prev_en);
            tick(1);
            chk($sformatf("vec%0d_mode", i), int'(mode), vecs[i].mode);
            chk($sformatf("vec%0d_en", i), en_bits(), int'(vecs[i].en));
            drive(5'b00000);
            tick(8);
            prev_mode = vecs[i].mode;
            prev_en   = int'(vecs[i].en);
        end
        chk("table_up_pulses", up_log.size(), 0);
        chk("table_down_pulses", dn_log.size(), 0);

        // Auto-repeat in SET_TM: press at +7, repeats at +27, +32, ... while debounced high.
        press_btn(5'b00100);
        chk("rep_mode", int'(mode), 2);
        up_log.delete();
        dn_log.delete();
        t0 = cyc;
        drive(5'b00010);
        tick(60);
        drive(5'b00000);
        tick(10);
        exp_up.delete();
        exp_up.push_back(t0 + 7);
        for (int e = t0 + 27; e <= t0 + 66; e += 5) exp_up.push_back(e);
        chk("rep_count", up_log.size(), exp_up.size());
        for (int i = 0; i < exp_up.size() && i < up_log.size(); i++)
            chk($sformatf("rep_edge%0d", i), up_log[i] - t0, exp_up[i] - t0);
        chk("rep_down_pulses", dn_log.size(), 0);

        // Holding up in CLOCK gives nothing.
        press_btn(5'b10000);
        chk("clock_mode", int'(mode), 0);
        up_log.delete();
        drive(5'b00010);
        tick(40);
        drive(5'b00000);
        tick(10);
        chk("clock_up_pulses", up_log.size(), 0);

        // Up and down together: silence; releasing down restarts up's full delay.
        press_btn(5'b10000);
        chk("both_mode", int'(mode), 1);
        up_log.delete();
        dn_log.delete();
        drive(5'b00011);
        tick(40);
        chk("both_up_pulses", up_log.size(), 0);
        chk("both_down_pulses", dn_log.size(), 0);
        t0 = cyc;
        drive(5'b00010);
        tick(28);
        chk("after_d_count", up_log.size(), 1);
        if (up_log.size() > 0) chk("after_d_first", up_log[0] - t0, 26);
        drive(5'b00000);
        tick(10);
        chk("after_d_total", up_log.size(), 2);
        chk("after_d_down", dn_log.size(), 0);

        // Reset during auto-repeat in SET_AM.
        press_btn(5'b01000);
        chk("am_mode", int'(mode), 4);
        up_log.delete();
        drive(5'b00010);
        tick(30);
        chk("am_pre_reset_pulses", up_log.size(), 2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("mid_rst_mode", int'(mode), 0);
        chk("mid_rst_en", en_bits(), 0);
        chk("mid_rst_up", int'(up), 0);
        chk("mid_rst_down", int'(down), 0);
        n = up_log.size();
        tick(40);
        chk("post_rst_up_pulses", up_log.size() - n, 0);
        chk("post_rst_mode", int'(mode), 0);
        drive(5'b00000);
        tick(10);

        // Illegal state code recovers to CLOCK.
        up_log.delete();
        dn_log.delete();
        force dut.state = mode_t'(3'd6);
        #1;
        chk("illegal_next", int'(dut.state_next), 0);
        chk("illegal_en", en_bits(), 0);
        release dut.state;
        tick(1);
        chk("illegal_recover_mode", int'(mode), 0);
        tick(3);
        chk("illegal_pulses", up_log.size() + dn_log.size(), 0);

        chk("up_down_overlap", overlap, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/button_panel.md
# button_panel

Input front end for the alarm clock. It synchronizes and debounces five raw push-buttons (centre, left, right, up, down) and runs a mode FSM. The FSM produces the level enables that select time or alarm adjustment and the up/down step pulses consumed by the time and alarm counters. This block is the user-input side of the clock; the multiplexed seven-segment display is the output side.

## Interface
Parameters:
- DB_CYCLES, 500000: consecutive cycles a synchronized input must hold a new value before the debounced state accepts it (≥2).
- REPEAT_DELAY, 50000000: cycles up/down must stay held after its press pulse before auto-repeat starts.
- REPEAT_RATE, 10000000: cycles between auto-repeat pulses (≥2).

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- btn_c, btn_l, btn_r, btn_u, btn_d  in  1 each  raw, asynchronous, bouncing, active-high buttons.
- mode  out  3  current FSM state code.
- adjust  out  1  high in SET_TH and SET_TM; selects the fast clock for time setting.
- enth, entm, enah, enam  out  1 each  one-hot field enables, high in SET_TH, SET_TM, SET_AH and SET_AM respectively.
- up, down  out  1 each  single-cycle step pulses.

## Operation
- **Per button:**
  - 2-flop synchronizer produces s.
  - A counter increments while s ≠ stable and clears while s = stable.
  - When the counter reaches DB_CYCLES−1 with s ≠ stable, stable ← s and the counter clears.
  - press = stable & ~stable_d, a one-cycle strobe.
- **Mode FSM, state codes:** CLOCK=0, SET_TH=1, SET_TM=2, SET_AH=3, SET_AM=4. Codes 5–7 are illegal and go to CLOCK on the next edge.
- **Transitions:**
  - c press: CLOCK→SET_TH; any SET_* state → CLOCK.
  - r press: SET_TH→SET_TM→SET_AH→SET_AM→SET_TH (wraps).
  - l press: the reverse cycle, SET_TH→SET_AM (wraps).
  - l and r are ignored in CLOCK.
- **Priority on simultaneous presses in the same cycle:** c beats l and r. l and r together produce no move.
- **Outputs:** mode and all level enables are decoded from the registered state. In CLOCK all enables and adjust are 0.
- **Up/down:**
  - Active only in SET_* states; never pulse in CLOCK.
  - A press strobe gives one pulse on the corresponding output.
  - While still held, a per-direction hold counter runs. At REPEAT_DELAY cycles after the press pulse, one pulse fires, then one every REPEAT_RATE cycles until release.
  - Both up and down debounced-high: no pulses from either, and the hold counter clears. After one is released, the remaining one waits a full REPEAT_DELAY before it repeats; it gets no fresh press pulse.
  - A mode change, including to CLOCK, clears the hold counter.
- **Reset:** all synchronizers, stable, stable_d and counters go to 0; state = CLOCK; every output 0. A button held through reset release is treated as a new press once debounced.

## Timing
- Raw edge sampled at edge 0 → s changes at edge 2 → stable changes at edge 2+DB_CYCLES.
- The press strobe is combinational in that cycle. The state register, level outputs and up/down pulse all update at edge 3+DB_CYCLES.
- up/down pulses are high exactly one cycle, and never high in the same cycle as each other.
- A bounce (s returning to stable) before the count completes restarts the full DB_CYCLES window.
- Release is debounced identically and produces no pulse.
- Reset mid-debounce or mid-repeat discards all progress.

## Structure
- Shared package button_panel_pkg holds:
  - the state-code localparams CLOCK, SET_TH, SET_TM, SET_AH, SET_AM;
  - the 3-bit mode width constant, reused by the display mux select.
- Sub-module btn_debounce:
  - parameter DB_CYCLES;
  - ports clk, rst, raw → stable, press;
  - instantiated five times.
- The FSM and the repeat logic live in button_panel.

## Test plan
Bench parameters: DB_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=5.
- **Debounce latency:** reset, raise btn_c cleanly at edge 0 → mode=1, adjust=1, enth=1 at edge 7; no change before it. Toggle btn_c with a period of 3 cycles for 30 cycles → mode unchanged.
- **Mode wrap:** from SET_TH, four r presses → mode 2,3,4,1. Then one l press → 4. c press → mode 0 with all enables 0. l press in CLOCK → stays 0.
- **Auto-repeat:** in SET_TM, hold btn_u 60 cycles → first up pulse at edge 7, repeat pulses 20, 25, 30… cycles after it, each 1 cycle wide. Release → no further pulses. Hold btn_u in CLOCK → zero pulses.
- **Simultaneous events:**
  - c and r pressed the same cycle from SET_TH → CLOCK.
  - u and d held together → zero pulses.
  - Then release d → u's first repeat pulse comes 20 cycles later.
- **Reset mid-operation:** assert rst for 1 cycle during an auto-repeat in SET_AM → next cycle mode=0 and all outputs 0. With btn_u still held, no pulse appears because the state is CLOCK.
- **Illegal state:** force state=6 → CLOCK on the next edge, no pulses.
